// File: rtl/l2_pipe_arb.sv
// l2_pipe_arb: pipe1/pipe2 arbiter feeding a one-entry state-array register.
// Optional starvation guard for pipe1: define L2_ARB_STARVE_GUARD_EN.
module l2_pipe_arb #(
  parameter int INDEX_W    = 8,
  parameter int STARVE_MAX = 4,
  parameter int HAZ_CYC    = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               p1_req_valid,
  input  logic [INDEX_W-1:0] p1_req_index,
  input  logic               p1_req_wr,
  input  logic               p2_req_valid,
  input  logic [INDEX_W-1:0] p2_req_index,
  input  logic               p2_req_wr,
  output logic               p1_gnt,
  output logic               p2_gnt,
  output logic               sa_valid,
  output logic [INDEX_W-1:0] sa_index,
  output logic               sa_wr,
  output logic               sa_src,
  input  logic               sa_ready,
  output logic               busy
);

  localparam int CW = $clog2(HAZ_CYC + 1);
  localparam logic IDLE = 1'b0;
  localparam logic HELD = 1'b1;

  if (STARVE_MAX < 1 || HAZ_CYC < 1) begin : g_param_chk
    $error("l2_pipe_arb: STARVE_MAX and HAZ_CYC must be >= 1");
  end

  logic               state;
  logic               slot_free;
  logic               wr_acc;
  logic               wr1;
  logic               wr2;
  logic [INDEX_W-1:0] h1_idx;
  logic [INDEX_W-1:0] h2_idx;
  logic [CW-1:0]      h1_cnt;
  logic [CW-1:0]      h2_cnt;
  logic               blk1;
  logic               blk2;
  logic               e1;
  logic               e2;
  logic               p1_force;

  assign sa_valid  = (state == HELD);
  assign slot_free = (state == IDLE) || sa_ready;
  assign wr_acc    = (state == HELD) && sa_ready && sa_wr;
  assign wr1       = wr_acc && !sa_src;
  assign wr2       = wr_acc && sa_src;

  // An index is blocked from the cycle the other pipe's write is accepted
  // until that pipe's hazard counter drains to zero.
  assign blk1 = (wr2 && sa_index == p1_req_index)
             || (h2_cnt != '0 && h2_idx == p1_req_index);
  assign blk2 = (wr1 && sa_index == p2_req_index)
             || (h1_cnt != '0 && h1_idx == p2_req_index);

  assign e1 = p1_req_valid && !blk1;
  assign e2 = p2_req_valid && !blk2;

  assign p1_gnt = !rst && slot_free && e1 && (!e2 || p1_force);
  assign p2_gnt = !rst && slot_free && e2 && !p1_gnt;

  assign busy = sa_valid || (h1_cnt != '0) || (h2_cnt != '0);

  // Output slot: load on grant, release on ready, otherwise hold.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      sa_index <= '0;
      sa_wr    <= 1'b0;
      sa_src   <= 1'b0;
    end else if (p1_gnt || p2_gnt) begin
      state    <= HELD;
      sa_index <= p2_gnt ? p2_req_index : p1_req_index;
      sa_wr    <= p2_gnt ? p2_req_wr : p1_req_wr;
      sa_src   <= p2_gnt;
    end else if (sa_ready) begin
      state    <= IDLE;
    end
  end

  // Hazard window for indices written by pipe1.
  always_ff @(posedge clk) begin
    if (rst) begin
      h1_idx <= '0;
      h1_cnt <= '0;
    end else if (wr1) begin
      h1_idx <= sa_index;
      h1_cnt <= CW'(HAZ_CYC);
    end else if (h1_cnt != '0) begin
      h1_cnt <= h1_cnt - CW'(1);
    end
  end

  // Hazard window for indices written by pipe2.
  always_ff @(posedge clk) begin
    if (rst) begin
      h2_idx <= '0;
      h2_cnt <= '0;
    end else if (wr2) begin
      h2_idx <= sa_index;
      h2_cnt <= CW'(HAZ_CYC);
    end else if (h2_cnt != '0) begin
      h2_cnt <= h2_cnt - CW'(1);
    end
  end

`ifdef L2_ARB_STARVE_GUARD_EN
  localparam int SW = $clog2(STARVE_MAX + 1);
  logic [SW-1:0] st_cnt;

  assign p1_force = (st_cnt == SW'(STARVE_MAX));

  // Count eligible pipe1 losses to pipe2; saturate at the limit.
  always_ff @(posedge clk) begin
    if (rst || p1_gnt || !p1_req_valid) begin
      st_cnt <= '0;
    end else if (e1 && p2_gnt && !p1_force) begin
      st_cnt <= st_cnt + SW'(1);
    end
  end
`else
  assign p1_force = 1'b0;
`endif

endmodule

// File: doc/l2_pipe_arb.md
L2_PIPE_ARB -- requirements
Module: l2_pipe_arb

Interface
REQ-001 SHALL have parameter INDEX_W, default 8: state-array index width.
REQ-002 SHALL have parameter STARVE_MAX, default 4: consecutive pipe1 losses that force pipe1 priority.
REQ-003 SHALL have parameter HAZ_CYC, default 2: cycles a written index stays blocked to the other pipe.
REQ-004 SHALL have port clk  in  1  clock; reset rst, synchronous, active-high; clock clk.
REQ-005 SHALL have port rst  in  1  synchronous active-high reset.
REQ-006 SHALL have ports p1_req_valid in 1, p1_req_index in INDEX_W, p1_req_wr in 1: pipe1 (NoC1 request) access.
REQ-007 SHALL have ports p2_req_valid in 1, p2_req_index in INDEX_W, p2_req_wr in 1: pipe2 (NoC3 response) access.
REQ-008 SHALL have ports p1_gnt out 1, p2_gnt out 1: one-cycle grant pulses, one-hot or zero.
REQ-009 SHALL have ports sa_valid out 1, sa_index out INDEX_W, sa_wr out 1, sa_src out 1 (0=pipe1, 1=pipe2), sa_ready in 1: state-array port.
REQ-010 SHALL have port busy out 1: sa_valid or any hazard window active.

Function
REQ-011 SHALL implement a one-entry output register with FSM IDLE (sa_valid=0) and HELD (sa_valid=1).
REQ-012 SHALL treat the slot as free when state is IDLE or when state is HELD and sa_ready=1 in the same cycle.
REQ-013 SHALL issue at most one grant per cycle, only when the slot is free; the granted request loads sa_* on the next edge, so sa_valid rises 1 cycle after the grant.
REQ-014 SHALL transition IDLE->HELD on a grant, HELD->IDLE on sa_ready with no grant, and stay HELD on sa_ready with a grant.
REQ-015 SHALL hold sa_index, sa_wr, sa_src stable while sa_valid=1 and sa_ready=0.
REQ-016 SHALL give pipe2 fixed priority when both pipes are eligible, except as stated in REQ-019.
REQ-017 SHALL make a request ineligible when its index equals an index written by the other pipe within the last HAZ_CYC cycles; a write is counted from the cycle sa_valid and sa_ready and sa_wr are all high.
REQ-018 SHALL track the hazard with one index register and a down-counter per pipe; a new accepted write reloads the counter to HAZ_CYC, and the counter saturates at 0.
REQ-019 SHALL count the cycles in which p1_req_valid=1, pipe1 is eligible, and p2 is granted; at STARVE_MAX the count SHALL force a pipe1 grant on its next eligible free-slot cycle.
REQ-020 SHALL clear the starvation count on any p1_gnt or when p1_req_valid=0.
REQ-021 SHALL NOT issue a grant for a request whose valid drops in the same cycle; requesters keep valid and fields stable until granted.

Reset
REQ-022 SHALL on rst force state IDLE, sa_valid=0, sa_index=0, sa_wr=0, sa_src=0, p1_gnt=0, p2_gnt=0, hazard counters=0, starvation count=0, busy=0.
REQ-023 SHALL drop an in-flight HELD entry on reset mid-operation without presenting it again.

Configuration
REQ-024 SHALL use the macro L2_ARB_STARVE_GUARD_EN: when defined, REQ-019 and REQ-020 apply; when undefined, the starvation counter SHALL be absent and pipe2 SHALL always win.

Verification
REQ-025 SHALL check: only p1 valid, index 0x10, sa_ready=1 -> p1_gnt at cycle 0, sa_valid with sa_src=0 and sa_index=0x10 at cycle 1, IDLE at cycle 2.
REQ-026 SHALL check: p1 and p2 valid every cycle, sa_ready=1, macro defined -> sa_src sequence 1,1,1,1,0,1,...
REQ-027 SHALL check: same stimulus with the macro undefined -> sa_src=1 on every issue and p1 is never granted.
REQ-028 SHALL check: p2 write to index 0x22 accepted at cycle t, p1 read to 0x22 pending -> p1_gnt no earlier than t+HAZ_CYC+1, while a p1 read to 0x23 is granted at once.
REQ-029 SHALL check: sa_ready held 0 for 5 cycles with both pipes valid -> no grants, sa_* stable, first new grant in the cycle sa_ready=1.
REQ-030 SHALL check: rst asserted while HELD -> next cycle sa_valid=0, busy=0, and the dropped entry does not reappear.
